round_ctrl: RTL
===============

Name: round_ctrl

Overview:
Game-flow sequencer for the two-player arena. Runs the round state machine (idle, clear, countdown, play, over) and issues a one-cycle synchronous clear pulse to the arena/bomb/character datapath. Generates the gated character-move and bomb strobes that pace that datapath, latches the round result from the bomb block's game_state, and keeps a saturating per-player match score for the seven-segment display.

Parameters:
TICK_DIV, 25_000_000, clk cycles per character tick (4 Hz at 100 MHz); minimum 2
BOMB_DIV, 4, character ticks per bomb tick (1 Hz); minimum 1
COUNTDOWN, 3, bomb ticks of pre-round countdown; minimum 1, maximum 3
OVER_HOLD, 5, bomb ticks spent in OVER before auto-return to IDLE; minimum 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  debounced start level (center button); rising edge is the request
abort  in  1  synchronous; forces IDLE from any state
game_state  in  2  from bomb block: 0 playing, 1 A wins, 2 B wins, 3 draw
clear  out  1  one-cycle synchronous clear to arena, bombs, players and health
char_tick  out  1  one-cycle character-move strobe, PLAY only
bomb_tick  out  1  one-cycle bomb strobe, PLAY only
move_en  out  1  high while in PLAY
phase  out  3  current state encoding
countdown  out  2  remaining countdown value; 0 outside COUNT
winner  out  2  latched result, same encoding as game_state
score_a  out  4  player A round wins, saturates at 9
score_b  out  4  player B round wins, saturates at 9

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. clear, char_tick, bomb_tick, move_en, countdown, winner, score_a and score_b are all 0. Divider counters and start_q are 0.
- Start edge: start_edge = start & ~start_q. start_q is registered every cycle.
- Tick generation:
  - div_cnt counts 0..TICK_DIV-1; raw_char is high on the wrap.
  - sub_cnt advances on raw_char and counts 0..BOMB_DIV-1; raw_bomb = raw_char & (sub_cnt==BOMB_DIV-1).
  - Both counters are forced to 0 while clear=1, so the first raw_char occurs TICK_DIV cycles after CLEAR.
- All outputs are registered.
  - char_tick in the next cycle = raw_char & (state==PLAY) & (game_state==0).
  - bomb_tick uses the same rule with raw_bomb.
- IDLE: start_edge -> CLEAR.
- CLEAR: clear=1 for exactly this one cycle; countdown is loaded with COUNTDOWN; next state COUNT.
- COUNT: on raw_bomb, if countdown==1 go to PLAY with countdown=0; otherwise decrement countdown. start_edge is ignored.
- PLAY: move_en=1. When game_state!=0 is sampled:
  - next state is OVER;
  - winner latches game_state;
  - result 1 increments score_a, result 2 increments score_b, result 3 increments both;
  - each score saturates at 9;
  - a hold counter is loaded with OVER_HOLD.
  start_edge is ignored in PLAY.
- OVER: decrement the hold counter on raw_bomb and go to IDLE when it reaches 0. start_edge -> CLEAR (rematch), taking priority over the hold expiry in the same cycle. winner is held.
- abort: takes priority over every transition. Next state IDLE; countdown=0; a pending clear is dropped. Scores and winner are preserved.
- winner is cleared to 0 on entry to CLEAR. Scores are cleared only by rst.
- Same-cycle events:
  - game_state!=0 with raw_bomb or raw_char in PLAY: the tick is suppressed and OVER is entered.
  - start_edge with abort: abort wins.
- phase encoding: IDLE=0, CLEAR=1, COUNT=2, PLAY=3, OVER=4; values 5-7 are unreachable and recover to IDLE.

Decomposition:
- Shared package round_pkg holds:
  - state encodings;
  - game_state codes GS_PLAY=0, GS_A=1, GS_B=2, GS_DRAW=3;
  - SCORE_MAX=9.
- Sub-module tick_gen holds div_cnt and sub_cnt. It takes clk, rst, sclr, and TICK_DIV/BOMB_DIV as parameters, and outputs raw_char and raw_bomb. The FSM, score logic and output gating stay in round_ctrl.

Test Plan:
Bench parameters: TICK_DIV=4, BOMB_DIV=2, COUNTDOWN=3, OVER_HOLD=2.
1. Reset, then raise start at cycle 10 -> clear=1 only in cycle 12; phase=2 and countdown=3 at cycle 13. countdown steps 3->2->1 every 8 cycles, then phase=3. No char_tick or bomb_tick before PLAY.
2. In PLAY, hold game_state=0 for 40 cycles -> char_tick every 4 cycles and bomb_tick every 8 cycles, each exactly 1 cycle wide, move_en=1 throughout.
3. Drive game_state=2 coincident with a raw_bomb cycle -> no bomb_tick, phase=4, winner=2, score_b=1, score_a=0. phase returns to 0 two bomb periods (16 cycles) later.
4. Play ten rounds ending in game_state=3 -> score_a=score_b=9 after round 9, and both remain 9 after round 10.
5. Pulse start during OVER -> clear pulses, winner goes to 0, scores are kept. Pulse start during PLAY -> no effect.
6. Assert abort during COUNT, then drop rst to 0 mid-PLAY asynchronously -> abort gives phase=0 next cycle with scores kept. The rst drop zeroes all outputs, including scores, immediately with no clock edge.

Source files
------------

// File: rtl/round_pkg.sv
// Shared encodings for the round sequencer: FSM states, bomb-block result codes
// and score limits.
package round_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_COUNT = 3'd2,
    ST_PLAY  = 3'd3,
    ST_OVER  = 3'd4
  } roundState_t;

  localparam logic [1:0] GS_PLAY = 2'd0;
  localparam logic [1:0] GS_A    = 2'd1;
  localparam logic [1:0] GS_B    = 2'd2;
  localparam logic [1:0] GS_DRAW = 2'd3;

  localparam logic [3:0] SCORE_MAX = 4'd9;

  function automatic logic [3:0] satInc(input logic [3:0] s);
    return (s >= SCORE_MAX) ? SCORE_MAX : s + 4'd1;
  endfunction

endpackage

// File: rtl/round_ctrl_tick_gen.sv
// Free-running character/bomb tick dividers, re-phased by a synchronous clear so
// that each round starts from a known tick alignment.
module tick_gen #(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned BOMB_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sclr,
  output logic raw_char,
  output logic raw_bomb
);

  localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (BOMB_DIV > 1) ? $clog2(BOMB_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(BOMB_DIV - 1);

  logic [DW-1:0] divCnt;
  logic [SW-1:0] subCnt;

  assign raw_char = (divCnt == DIV_LAST);
  assign raw_bomb = raw_char && (subCnt == SUB_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divCnt <= '0;
      subCnt <= '0;
    end else if (sclr) begin
      divCnt <= '0;
      subCnt <= '0;
    end else begin
      divCnt <= raw_char ? '0 : divCnt + 1'b1;
      if (raw_char) begin
        subCnt <= (subCnt == SUB_LAST) ? '0 : subCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/round_ctrl.sv
// Round sequencer for the two-player arena: FSM, datapath clear, gated move/bomb
// strobes, result latch and saturating match score.
module round_ctrl
  import round_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 25_000_000,
  parameter int unsigned BOMB_DIV  = 4,
  parameter int unsigned COUNTDOWN = 3,
  parameter int unsigned OVER_HOLD = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] game_state,
  output logic       clear,
  output logic       char_tick,
  output logic       bomb_tick,
  output logic       move_en,
  output logic [2:0] phase,
  output logic [1:0] countdown,
  output logic [1:0] winner,
  output logic [3:0] score_a,
  output logic [3:0] score_b
);

  localparam int unsigned HW = $clog2(OVER_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(OVER_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(1);
  localparam logic [1:0]    CD_LOAD   = 2'(COUNTDOWN);

  roundState_t   state;
  logic          startQ;
  logic          startEdge;
  logic [HW-1:0] holdCnt;
  logic          rawChar;
  logic          rawBomb;
  logic          inPlayLive;

  tick_gen #(
    .TICK_DIV(TICK_DIV),
    .BOMB_DIV(BOMB_DIV)
  ) uTickGen (
    .clk     (clk),
    .rst     (rst),
    .sclr    (clear),
    .raw_char(rawChar),
    .raw_bomb(rawBomb)
  );

  assign startEdge  = start && !startQ;
  assign inPlayLive = (state == ST_PLAY) && (game_state == GS_PLAY);
  assign phase      = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      startQ    <= 1'b0;
      clear     <= 1'b0;
      char_tick <= 1'b0;
      bomb_tick <= 1'b0;
      move_en   <= 1'b0;
      countdown <= '0;
      winner    <= '0;
      score_a   <= '0;
      score_b   <= '0;
      holdCnt   <= '0;
    end else begin
      startQ    <= start;
      clear     <= 1'b0;
      char_tick <= rawChar && inPlayLive;
      bomb_tick <= rawBomb && inPlayLive;

      // abort overrides every transition, including a CLEAR about to be issued
      if (abort) begin
        state     <= ST_IDLE;
        countdown <= '0;
        move_en   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (startEdge) begin
              state  <= ST_CLEAR;
              clear  <= 1'b1;
              winner <= '0;
            end
          end
          ST_CLEAR: begin
            state     <= ST_COUNT;
            countdown <= CD_LOAD;
          end
          ST_COUNT: begin
            if (rawBomb) begin
              if (countdown == 2'd1) begin
                state     <= ST_PLAY;
                countdown <= '0;
                move_en   <= 1'b1;
              end else begin
                countdown <= countdown - 2'd1;
              end
            end
          end
          ST_PLAY: begin
            if (game_state != GS_PLAY) begin
              state   <= ST_OVER;
              move_en <= 1'b0;
              winner  <= game_state;
              holdCnt <= HOLD_LOAD;
              if (game_state == GS_A || game_state == GS_DRAW) score_a <= satInc(score_a);
              if (game_state == GS_B || game_state == GS_DRAW) score_b <= satInc(score_b);
            end
          end
          ST_OVER: begin
            if (startEdge) begin
              state  <= ST_CLEAR;
              clear  <= 1'b1;
              winner <= '0;
            end else if (rawBomb) begin
              holdCnt <= holdCnt - 1'b1;
              if (holdCnt == HOLD_LAST) state <= ST_IDLE;
            end
          end
          default: begin
            state   <= ST_IDLE;
            move_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
